crc_stream_engine: RTL and testbench

- Sequential, parametrised successor to the team's combinational CRC evaluator.
- Accumulates a CRC over a stream of WDATA-bit words, processing BPC bits per clock, MSB first, with a programmable polynomial and init value.
- Supports multi-word messages with valid/ready handshake, last-word flag, done pulse and optional compare against an expected CRC.
- Sits behind the SPI execution unit, checking RX frames and generating TX CRC.

---
 rtl/crc_stream_engine.sv | 141 ++++++++++++++
 tb/tb_crc_stream_engine.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: accumulates a CRC over WDATA-bit words, BPC bits per
// clock MSB first, with programmable polynomial, init value and result compare.
module crc_stream_engine #(
  parameter int WDATA = 8,
  parameter int WPOLY = 4,
  parameter int BPC   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WPOLY-2:0] i_init,
  input  logic [WPOLY-1:0] i_poly,
  input  logic             i_valid,
  input  logic [WDATA-1:0] i_data,
  input  logic             i_last,
  input  logic [WPOLY-2:0] i_chk,
  output logic             o_ready,
  output logic             o_busy,
  output logic [WPOLY-2:0] o_crc,
  output logic             o_done,
  output logic             o_match
);

  localparam int WCRC = WPOLY - 1;
  localparam int NCYC = WDATA / BPC;
  localparam int WCNT = (NCYC > 1) ? $clog2(NCYC) : 1;

  if ((BPC < 1) || ((WDATA % BPC) != 0)) begin : g_bad_bpc
    $error("crc_stream_engine: BPC must divide WDATA");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q;
  logic [WCRC-1:0]  crc_q;
  logic [WCRC-1:0]  crc_d;
  logic [WCRC-1:0]  ocrc_q;
  logic [WCRC-1:0]  poly_q;
  logic [WDATA-1:0] data_q;
  logic             last_q;
  logic [WCNT-1:0]  cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             match_q;
  logic             fb;
  logic             cnt_last;
  logic             unused_poly_msb;

  // The polynomial MSB is always an implicit 1.
  assign unused_poly_msb = i_poly[WPOLY-1];

  always_comb begin
    crc_d = crc_q;
    fb    = 1'b0;
    for (int i = 0; i < BPC; i++) begin
      fb    = crc_d[WCRC-1] ^ data_q[WDATA-1-i];
      crc_d = (crc_d << 1) ^ (fb ? poly_q : '0);
    end
  end

  assign cnt_last = (cnt_q == WCNT'(NCYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      crc_q   <= '0;
      ocrc_q  <= '0;
      poly_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else if (i_start) begin
      state_q <= IDLE;
      crc_q   <= i_init;
      ocrc_q  <= i_init;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            state_q <= SHIFT;
            data_q  <= i_data;
            poly_q  <= i_poly[WCRC-1:0];
            last_q  <= i_last;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          crc_q  <= crc_d;
          data_q <= data_q << BPC;
          cnt_q  <= cnt_q + WCNT'(1);
          if (cnt_last) begin
            ocrc_q <= crc_d;
            busy_q <= 1'b0;
            if (last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              match_q <= (crc_d == i_chk);
            end else begin
              state_q <= IDLE;
              ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_crc   = ocrc_q;
  assign o_done  = done_q;
  assign o_match = match_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: three instances (8b/1bpc, 8b/2bpc,
// 7b/1bpc) share control inputs so BPC variants see identical streams.
module tb_crc_stream_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] init = '0;
  logic [3:0] poly = 4'b1011;
  logic       valid = 1'b0;
  logic [7:0] d8 = '0;
  logic [6:0] d7 = '0;
  logic       lst = 1'b0;
  logic [2:0] chk = '0;

  logic       rdy8, bsy8, dn8, mt8;
  logic       rdy2, bsy2, dn2, mt2;
  logic       rdy7, bsy7, dn7, mt7;
  logic [2:0] crc8, crc2, crc7;

  int checks = 0;
  int errors = 0;
  int n_done8 = 0;
  int n_done7 = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dn8) n_done8++;
    if (dn7) n_done7++;
  end

  crc_stream_engine #(.WDATA(8), .WPOLY(4), .BPC(1)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_init(init),
    .i_poly(poly), .i_valid(valid), .i_data(d8), .i_last(lst),
    .i_chk(chk), .o_ready(rdy8), .o_busy(bsy8), .o_crc(crc8),
    .o_done(dn8), .o_match(mt8)
  );

  crc_stream_engine #(.WDATA(8), .WPOLY(4), .BPC(2)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_init(init),
    .i_poly(poly), .i_valid(valid), .i_data(d8), .i_last(lst),
    .i_chk(chk), .o_ready(rdy2), .o_busy(bsy2), .o_crc(crc2),
    .o_done(dn2), .o_match(mt2)
  );

  crc_stream_engine #(.WDATA(7), .WPOLY(4), .BPC(1)) u7 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_init(init),
    .i_poly(poly), .i_valid(valid), .i_data(d7), .i_last(lst),
    .i_chk(chk), .o_ready(rdy7), .o_busy(bsy7), .o_crc(crc7),
    .o_done(dn7), .o_match(mt7)
  );

  // Long division of message*x^3 by x^3+x+1, init 0.
  function automatic logic [2:0] ref_crc(input logic [7:0] w [5]);
    logic [2:0] r;
    logic [3:0] t;
    r = '0;
    for (int k = 0; k < 43; k++) begin
      t = {r, (k < 40) ? w[k/8][7-(k%8)] : 1'b0};
      if (t[3]) t = t ^ 4'b1011;
      r = t[2:0];
    end
    return r;
  endfunction

  task automatic do_start(input logic [2:0] iv);
    start = 1'b1;
    init  = iv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] w8, input logic [6:0] w7,
                      input logic l);
    int t;
    t = 0;
    while (!(rdy8 && rdy2 && rdy7) && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 40) begin
      errors++;
      $display("FAIL send_wait: ready=%b%b%b, want 111", rdy8, rdy2, rdy7);
    end
    d8 = w8;
    d7 = w7;
    lst = l;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    lst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({crc8, rdy8, bsy8, dn8, mt8} !== 7'b000_1000) begin
      errors++;
      $display("FAIL reset_u8: crc=%b r=%b b=%b d=%b m=%b, want 000 1 0 0 0",
               crc8, rdy8, bsy8, dn8, mt8);
    end
    checks++;
    if ({rdy2, rdy7, bsy2, bsy7} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_others: rdy=%b%b busy=%b%b, want 11 00",
               rdy2, rdy7, bsy2, bsy7);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word;
    int t;
    chk = 3'b011;
    do_start(3'b000);
    send(8'h01, 7'h00, 1'b1);
    poly = 4'b1101;
    t = 0;
    while (!dn8 && t < 30) begin
      @(negedge clk);
      t++;
    end
    poly = 4'b1011;
    checks++;
    if (t !== 8) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, want 8", t);
    end
    checks++;
    if (crc8 !== 3'b011) begin
      errors++;
      $display("FAIL single_crc: got %b, want 011", crc8);
    end
    checks++;
    if (mt8 !== 1'b1) begin
      errors++;
      $display("FAIL single_match: got %b, want 1", mt8);
    end
    @(negedge clk);
    checks++;
    if ({dn8, rdy8, mt8} !== 3'b011) begin
      errors++;
      $display("FAIL single_after: done=%b ready=%b match=%b, want 0 1 1",
               dn8, rdy8, mt8);
    end
  endtask

  task automatic test_mismatch;
    int t;
    chk = 3'b011;
    do_start(3'b000);
    send(8'h02, 7'h00, 1'b1);
    t = 0;
    while (!dn8 && t < 30) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (crc8 !== 3'b110 || mt8 !== 1'b0 || t !== 8) begin
      errors++;
      $display("FAIL mismatch: crc=%b match=%b lat=%0d, want 110 0 8",
               crc8, mt8, t);
    end
  endtask

  task automatic test_two_words_w7;
    int t;
    int snap;
    chk = 3'b100;
    do_start(3'b000);
    snap = n_done7;
    send(8'h00, 7'b1101001, 1'b0);
    t = 0;
    while (!rdy7 && t < 30) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (crc7 !== 3'b000 || n_done7 !== snap || t !== 7) begin
      errors++;
      $display("FAIL w7_first: crc=%b dones=%0d lat=%0d, want 000 %0d 7",
               crc7, n_done7, t, snap);
    end
    send(8'h00, 7'b1101100, 1'b1);
    t = 0;
    while (!dn7 && t < 30) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (crc7 !== 3'b100 || mt7 !== 1'b1) begin
      errors++;
      $display("FAIL w7_final: crc=%b match=%b, want 100 1", crc7, mt7);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_done7 !== snap + 1) begin
      errors++;
      $display("FAIL w7_done_count: got %0d, want %0d", n_done7 - snap, 1);
    end
  endtask

  task automatic test_bpc;
    logic [7:0] w [5];
    logic [2:0] exp_crc;
    int lo8;
    int lo2;
    w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'hFF; w[3] = 8'h00; w[4] = 8'h81;
    exp_crc = ref_crc(w);
    chk = 3'b000;
    do_start(3'b000);
    for (int n = 0; n < 5; n++) begin
      send(w[n], 7'h00, n == 4);
      lo8 = 0;
      lo2 = 0;
      for (int c = 0; c < 12; c++) begin
        if (!rdy8) lo8++;
        if (!rdy2) lo2++;
        @(negedge clk);
      end
      checks++;
      if (lo8 !== 8 + (n == 4) || lo2 !== 4 + (n == 4)) begin
        errors++;
        $display("FAIL bpc_ready_low word%0d: bpc1=%0d bpc2=%0d, want %0d %0d",
                 n, lo8, lo2, 8 + (n == 4), 4 + (n == 4));
      end
    end
    checks++;
    if (crc8 !== exp_crc || crc2 !== exp_crc) begin
      errors++;
      $display("FAIL bpc_crc: bpc1=%b bpc2=%b, want %b", crc8, crc2, exp_crc);
    end
  endtask

  task automatic test_async_reset;
    int t;
    do_start(3'b101);
    checks++;
    if (crc8 !== 3'b101) begin
      errors++;
      $display("FAIL start_init: got %b, want 101", crc8);
    end
    send(8'hFF, 7'h00, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({crc8, rdy8, bsy8, dn8, mt8} !== 7'b000_1000) begin
      errors++;
      $display("FAIL async_reset: crc=%b r=%b b=%b d=%b m=%b, want 000 1 0 0 0",
               crc8, rdy8, bsy8, dn8, mt8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    chk = 3'b011;
    send(8'h01, 7'h00, 1'b1);
    t = 0;
    while (!dn8 && t < 30) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (crc8 !== 3'b011 || mt8 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_word: crc=%b match=%b, want 011 1", crc8, mt8);
    end
    @(negedge clk);
  endtask

  task automatic test_start_abort;
    int snap;
    chk = 3'b000;
    send(8'hFF, 7'h00, 1'b1);
    snap = n_done8;
    repeat (2) @(negedge clk);
    start = 1'b1;
    init = 3'b101;
    valid = 1'b1;
    d8 = 8'h01;
    lst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b0;
    lst = 1'b0;
    checks++;
    if ({crc8, rdy8, bsy8, dn8, mt8} !== 7'b101_1000) begin
      errors++;
      $display("FAIL abort: crc=%b r=%b b=%b d=%b m=%b, want 101 1 0 0 0",
               crc8, rdy8, bsy8, dn8, mt8);
    end
    @(negedge clk);
    checks++;
    if (bsy8 !== 1'b0 || rdy8 !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_accept: busy=%b ready=%b, want 0 1", bsy8, rdy8);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (n_done8 !== snap || crc8 !== 3'b101) begin
      errors++;
      $display("FAIL abort_no_done: dones=%0d crc=%b, want 0 101",
               n_done8 - snap, crc8);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_mismatch();
    test_two_words_w7();
    test_bpc();
    test_async_reset();
    test_start_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
